// File: rtl/tc_count10.sv
// tc_count10: loadable up-counter with prescaler, all-ones terminal detect,
// periodic auto-reload or one-shot halt, and a one-cycle wrap pulse.
module tc_count10 #(
  parameter int WIDTH = 10,
  parameter int PRE_W = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic [PRE_W-1:0] pre,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc_n,
  output logic             tick,
  output logic             busy
);

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [PRE_W-1:0] prescaler_reg, prescaler_next;
  logic             mode_reg, mode_next;
  logic             tick_reg, tick_next;
  logic             all_ones;

  assign all_ones = &cnt_reg;

  // Next-state decode: load wins over any advance; a terminal advance either
  // reloads (periodic) or parks at all-ones and drops to IDLE (one-shot).
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    reload_next    = reload_reg;
    pre_next       = pre_reg;
    prescaler_next = prescaler_reg;
    mode_next      = mode_reg;
    tick_next      = 1'b0;
    if (ld) begin
      cnt_next       = din;
      reload_next    = din;
      pre_next       = pre;
      mode_next      = mode;
      prescaler_next = '0;
      state_next     = RUN;
    end else if (state_reg == RUN && en) begin
      if (prescaler_reg == pre_reg) begin
        prescaler_next = '0;
        if (all_ones) begin
          tick_next = 1'b1;
          if (mode_reg) begin
            state_next = IDLE;
          end else begin
            cnt_next = reload_reg;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end else begin
        prescaler_next = prescaler_reg + PRE_ONE;
      end
    end
  end

  // State registers with synchronous reset; reset discards any pending tick.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      reload_reg    <= '0;
      pre_reg       <= '0;
      prescaler_reg <= '0;
      mode_reg      <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      reload_reg    <= reload_next;
      pre_reg       <= pre_next;
      prescaler_reg <= prescaler_next;
      mode_reg      <= mode_next;
      tick_reg      <= tick_next;
    end
  end

  assign cnt  = cnt_reg;
  assign tc_n = ~all_ones;
  assign tick = tick_reg;
  assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_tc_count10.sv
// tb_tc_count10: directed scenarios plus randomized traffic, every cycle
// compared against an integer-level behavioural model of the counter.
module tb_tc_count10;

  logic       sys_clk = 1'b0;
  logic       reset, ld, mode, en;
  logic [9:0] din;
  logic [3:0] pre;
  logic [9:0] cnt;
  logic       tc_n, tick, busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, plain integers.
  int  m_cnt, m_reload, m_pre, m_phase;
  bit  m_oneshot, m_tick, m_busy;

  tc_count10 #(.WIDTH(10), .PRE_W(4)) dut (
    .sys_clk(sys_clk), .reset(reset), .ld(ld), .din(din), .pre(pre),
    .mode(mode), .en(en), .cnt(cnt), .tc_n(tc_n), .tick(tick), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Apply the rules to the model for one rising edge with the given inputs.
  task automatic model_edge(input bit r, input bit l, input int d, input int p,
                            input bit md, input bit e);
    if (r) begin
      m_cnt = 0; m_reload = 0; m_pre = 0; m_phase = 0;
      m_oneshot = 0; m_tick = 0; m_busy = 0;
    end else if (l) begin
      m_cnt = d; m_reload = d; m_pre = p; m_oneshot = md;
      m_phase = 0; m_busy = 1; m_tick = 0;
    end else begin
      m_tick = 0;
      if (m_busy && e) begin
        if (m_phase == m_pre) begin
          m_phase = 0;
          if (m_cnt == 1023) begin
            m_tick = 1;
            if (m_oneshot) m_busy = 0;
            else m_cnt = m_reload;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock, update model, compare all outputs.
  task automatic step(input bit r, input bit l, input int d, input int p,
                      input bit md, input bit e);
    reset = r; ld = l; din = 10'(d); pre = 4'(p); mode = md; en = e;
    @(posedge sys_clk);
    model_edge(r, l, d, p, md, e);
    #1;
    check_val("cnt", int'(cnt), m_cnt);
    check_val("tc_n", int'(tc_n), (m_cnt == 1023) ? 0 : 1);
    check_val("tick", int'(tick), int'(m_tick));
    check_val("busy", int'(busy), int'(m_busy));
  endtask

  initial begin
    int tick_count;
    reset = 1; ld = 0; din = 0; pre = 0; mode = 0; en = 0;

    // 1: reset then idle
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
    check_val("idle_cnt", int'(cnt), 0);
    check_val("idle_busy", int'(busy), 0);

    // 2: periodic 3FC pre 0, wrap every 4 advances
    step(0, 1, 'h3FC, 0, 0, 1);
    check_val("ld_cnt", int'(cnt), 'h3FC);
    tick_count = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (tick) tick_count++;
    end
    check_val("periodic_ticks", tick_count, 3);

    // 3: one-shot 3FE pre 2, then en has no effect
    step(0, 1, 'h3FE, 2, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1);
    check_val("oneshot_hold", int'(cnt), 'h3FF);
    check_val("oneshot_idle", int'(busy), 0);

    // 4: periodic 3FD with en low for 3 cycles mid-count
    step(0, 1, 'h3FD, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

    // 5: ld coincident with terminal advance
    step(0, 1, 'h3FF, 0, 0, 1);
    step(0, 1, 'h123, 1, 0, 1);
    check_val("ld_over_tc_cnt", int'(cnt), 'h123);
    check_val("ld_over_tc_tick", int'(tick), 0);

    // 6: reset at all-ones with advance pending, then ld all-ones
    step(0, 1, 'h3FF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check_val("rst_tick", int'(tick), 0);
    step(0, 1, 'h3FF, 3, 0, 0);
    check_val("ld_ones_tcn", int'(tc_n), 0);

    // Randomized traffic, biased toward short periods near all-ones.
    for (int i = 0; i < 4000; i++) begin
      bit r, l, md, e;
      int d, p;
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 29) == 0);
      md = $urandom_range(0, 1) == 1;
      e  = ($urandom_range(0, 9) < 8);
      d  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1008, 1023))
                                       : int'($urandom_range(0, 1023));
      p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                       : int'($urandom_range(0, 3));
      step(r, l, d, p, md, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
